// File: rtl/risc_run_ctrl.sv
// rtl/risc_run_ctrl.sv - run controller: image load, core reset release, halt/timeout detect, register dump
//
// Sequences one run of the pipelined RISC core:
//   IDLE -> LOAD (stream image into RAM, core held in reset) -> CPURST (one cycle)
//   -> RUN (count cycles, watch PC for halt or timeout) -> DUMP (stream R0..NREGS-1) -> DONE
//
// Optional feature macro: RUN_CTRL_RETIRE_CNT_EN
//   defined   : `retired` counts RUN cycles with wb_valid set (saturating)
//   undefined : `retired` is constant 0 and wb_valid is ignored
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   start                begin a run (honoured only in IDLE / DONE)
//   ld_valid/ld_ready    image stream handshake; ld_addr, ld_data, ld_last carry the beat
//   mem_we/addr/wdata    RAM write port, combinational from the accepted beat
//   cpu_rst              active-high core reset
//   cpu_pc, wb_valid     core PC and retire strobe
//   rf_rd_idx/rf_rd_data register-file debug read port
//   dump_*               register dump stream (valid/ready, idx, data, last)
//   done, timeout        run status
//   cycles, retired      RUN cycle count and retired instruction count

module risc_run_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NREGS       = 8,
    parameter int IDX_W       = $clog2(NREGS),
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 140,
    parameter int HALT_STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic              wb_valid,
    output logic [IDX_W-1:0]  rf_rd_idx,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CPURST,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CYC_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_TOP = CNT_W'(HALT_STABLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NREGS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [ADDR_W-1:0]  prev_pc_q, prev_pc_d;
    logic [IDX_W-1:0]   dump_idx_q, dump_idx_d;
    logic               pc_eq;
    logic               halt_hit;
    logic               tmo_hit;

`ifdef RUN_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0]   retired_q, retired_d;
`else
    logic               unused_wb_valid;
    assign unused_wb_valid = wb_valid;
`endif

    assign pc_eq    = (cpu_pc == prev_pc_q);
    assign halt_hit = (state_q == S_RUN) && pc_eq && (stable_q == STABLE_TOP);
    assign tmo_hit  = (state_q == S_RUN) && (cycles_q == CYC_LAST);

    always_comb begin
        state_d    = state_q;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;
        stable_d   = stable_q;
        prev_pc_d  = prev_pc_q;
        dump_idx_d = dump_idx_q;
`ifdef RUN_CTRL_RETIRE_CNT_EN
        retired_d  = retired_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    cycles_d   = '0;
                    timeout_d  = 1'b0;
                    stable_d   = '0;
                    dump_idx_d = '0;
`ifdef RUN_CTRL_RETIRE_CNT_EN
                    retired_d  = '0;
`endif
                end
            end
            S_LOAD: begin
                if (ld_valid && ld_last) begin
                    state_d = S_CPURST;
                end
            end
            S_CPURST: begin
                // Reference PC for the first RUN compare is the reset PC.
                prev_pc_d = cpu_pc;
                stable_d  = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (cycles_q != CNT_MAX) begin
                    cycles_d = cycles_q + 1'b1;
                end
`ifdef RUN_CTRL_RETIRE_CNT_EN
                if (wb_valid && (retired_q != CNT_MAX)) begin
                    retired_d = retired_q + 1'b1;
                end
`endif
                prev_pc_d = cpu_pc;
                stable_d  = pc_eq ? stable_q + 1'b1 : '0;
                // Halt takes priority when both fire on the same cycle.
                if (halt_hit) begin
                    state_d   = S_DUMP;
                    timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d   = S_DUMP;
                    timeout_d = 1'b1;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (dump_idx_q == IDX_LAST) begin
                        dump_idx_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cycles_q   <= '0;
            timeout_q  <= 1'b0;
            stable_q   <= '0;
            prev_pc_q  <= '0;
            dump_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cycles_q   <= cycles_d;
            timeout_q  <= timeout_d;
            stable_q   <= stable_d;
            prev_pc_q  <= prev_pc_d;
            dump_idx_q <= dump_idx_d;
        end
    end

`ifdef RUN_CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end
    assign retired = retired_q;
`else
    assign retired = '0;
`endif

    // Write port is zeroed when no write is in progress so idle outputs stay quiet.
    assign ld_ready   = (state_q == S_LOAD);
    assign mem_we     = ld_ready && ld_valid;
    assign mem_addr   = mem_we ? ld_addr : '0;
    assign mem_wdata  = mem_we ? ld_data : '0;

    // Core runs only in RUN and DUMP; every other state, including reset, holds it in reset.
    assign cpu_rst    = !((state_q == S_RUN) || (state_q == S_DUMP));

    assign rf_rd_idx  = dump_idx_q;
    assign dump_idx   = dump_idx_q;
    assign dump_valid = (state_q == S_DUMP);
    assign dump_data  = dump_valid ? rf_rd_data : '0;
    assign dump_last  = dump_valid && (dump_idx_q == IDX_LAST);

    assign done       = (state_q == S_DONE);
    assign timeout    = timeout_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb/tb_risc_run_ctrl.sv - self-checking bench for risc_run_ctrl
module tb_risc_run_ctrl;

`ifdef RUN_CTRL_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic [15:0] cpu_pc;
    logic        wb_valid;
    logic [2:0]  rf_rd_idx;
    logic [15:0] rf_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [2:0]  dump_idx;
    logic [15:0] dump_data;
    logic        dump_last;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
        logic        exp_we;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } ld_vec_t;

    ld_vec_t vec [15];

    risc_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .cpu_pc     (cpu_pc),
        .wb_valid   (wb_valid),
        .rf_rd_idx  (rf_rd_idx),
        .rf_rd_data (rf_rd_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_last  (dump_last),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rf_val(input logic [2:0] i);
        return 16'hA000 + 16'(i) * 16'h0123;
    endfunction

    assign rf_rd_data = rf_val(rf_rd_idx);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the PC for RUN cycle n: mode 0 counts 0..20 then holds, mode 1 changes every cycle.
    task automatic run_core(input bit mode, output int n);
        n = 0;
        while (n < 400) begin
            cpu_pc   = mode ? 16'(1000 + n) : 16'((n < 20) ? n : 20);
            wb_valid = (n < 37);
            start    = (n == 5);
            tick();
            n++;
            if (dump_valid) break;
        end
        wb_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_dump(input bit mode);
        int k;
        int exp_idx;
        exp_idx = 0;
        for (k = 0; k < 40 && exp_idx < 8; k++) begin
            dump_ready = mode ? (k % 3 == 0) : 1'b1;
            #2;
            check("dump_valid", dump_valid, 1);
            check("dump_idx", dump_idx, exp_idx);
            check("dump_data", dump_data, rf_val(3'(exp_idx)));
            check("dump_last", dump_last, exp_idx == 7);
            if (dump_ready) exp_idx++;
            tick();
        end
        dump_ready = 1'b0;
        #2;
        check("dump_beats", exp_idx, 8);
        check("dump_cycles", k, mode ? 22 : 8);
        check("dump_done", done, 1);
        check("dump_valid_off", dump_valid, 0);
    endtask

    initial begin
        int n;
        int we_cnt;
        clk = 0; rst = 0; start = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
        ld_last = 0; cpu_pc = 0; wb_valid = 0; dump_ready = 0;

        vec[0] = '{1'b0, 16'd5, 16'h0077, 1'b0, 1'b0, 16'd0, 16'd0};
        for (int i = 0; i < 12; i++) begin
            vec[i+1] = '{1'b1, 16'(i), 16'(993 - 90 * i), 1'b0, 1'b1, 16'(i), 16'(993 - 90 * i)};
        end
        vec[13] = '{1'b1, 16'd25, 16'hFFFE, 1'b0, 1'b1, 16'd25, 16'hFFFE};
        vec[14] = '{1'b1, 16'd26, 16'd100, 1'b1, 1'b1, 16'd26, 16'd100};

        // Reset values
        tick(); tick(); #2;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycles", cycles, 0);
        check("rst_retired", retired, 0);
        check("rst_dump_idx", dump_idx, 0);
        rst = 1;
        tick();

        // Reset asserted mid-LOAD
        start = 1; tick(); start = 0; #1;
        check("midload_ld_ready", ld_ready, 1);
        ld_valid = 1; ld_addr = 3; ld_data = 9;
        tick(); tick();
        rst = 0; #1;
        check("midrst_cpu_rst", cpu_rst, 1);
        check("midrst_ld_ready", ld_ready, 0);
        check("midrst_mem_we", mem_we, 0);
        repeat (3) tick();
        check("midrst_done", done, 0);
        check("midrst_cycles", cycles, 0);
        ld_valid = 0; rst = 1;
        tick(); #1;
        check("post_rst_idle", ld_ready, 0);
        check("post_rst_cpu_rst", cpu_rst, 1);

        // Table-driven image load
        start = 1; tick(); start = 0;
        we_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            ld_valid = vec[i].valid; ld_addr = vec[i].addr;
            ld_data = vec[i].data; ld_last = vec[i].last;
            #2;
            check("ld_ready", ld_ready, 1);
            check("mem_we", mem_we, vec[i].exp_we);
            check("mem_addr", mem_addr, vec[i].exp_addr);
            check("mem_wdata", mem_wdata, vec[i].exp_data);
            check("ld_cpu_rst", cpu_rst, 1);
            if (mem_we) we_cnt++;
            tick();
        end
        ld_valid = 0; ld_last = 0; cpu_pc = 16'd0; #1;
        check("we_pulses", we_cnt, 14);
        check("cpurst_ld_ready", ld_ready, 0);
        check("cpurst_cpu_rst", cpu_rst, 1);
        tick(); #1;
        check("run_cpu_rst", cpu_rst, 0);

        // Halt run: PC settles at 20 in RUN cycle 20
        run_core(1'b0, n);
        check("halt_run_cycles", n, 25);
        check("halt_cycles", cycles, 25);
        check("halt_timeout", timeout, 0);
        check("halt_cpu_rst", cpu_rst, 0);
        do_dump(1'b0);
        check("halt_done_cycles", cycles, 25);
        check("halt_done_timeout", timeout, 0);
        check("halt_retired", retired, RET_EN ? 25 : 0);

        // Timeout run from DONE, with back-pressured dump
        start = 1; tick(); start = 0; #1;
        check("restart_cycles", cycles, 0);
        check("restart_retired", retired, 0);
        check("restart_timeout", timeout, 0);
        check("restart_done", done, 0);
        ld_valid = 1; ld_addr = 0; ld_data = 1; ld_last = 1;
        tick();
        ld_valid = 0; ld_last = 0; cpu_pc = 16'd1000;
        tick();
        run_core(1'b1, n);
        check("tmo_run_cycles", n, 140);
        check("tmo_timeout_dump", timeout, 1);
        do_dump(1'b1);
        check("tmo_done_cycles", cycles, 140);
        check("tmo_done_timeout", timeout, 1);
        check("tmo_retired", retired, RET_EN ? 37 : 0);

        // Second start clears everything
        start = 1; tick(); start = 0; #1;
        check("clr_cycles", cycles, 0);
        check("clr_retired", retired, 0);
        check("clr_timeout", timeout, 0);
        check("clr_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_run_ctrl.md
# risc_run_ctrl

Synthesisable run controller for the pipelined RISC core, replacing the fixed-time bench sequence of preload, reset, fixed wait and register print with a parametrised hardware sequence. It streams a program/data image into the core's RAM while holding the core in reset, then releases reset and counts cycles. It detects halt (PC stable) or a configurable timeout, then dumps the register file over a valid/ready stream. It sits between the bench or host link and the `risc` top, driving the RAM write port, the core reset and the register-file debug read port.

## Interface
- `DATA_W`, 16, RAM word and register width
- `ADDR_W`, 16, RAM address and PC width
- `NREGS`, 8, registers dumped (R0..R7); index width `IDX_W = $clog2(NREGS)`
- `CNT_W`, 16, width of the cycle and retire counters
- `MAX_CYCLES`, 140, RUN cycles before timeout (must be ≥ 1 and < 2^CNT_W)
- `HALT_STABLE`, 4, consecutive cycles with an unchanged PC that count as halt (≥ 1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `ld_valid`  in  1  image word valid
- `ld_ready`  out  1  controller accepts image word
- `ld_addr`  in  ADDR_W  RAM address of the word
- `ld_data`  in  DATA_W  word value
- `ld_last`  in  1  final image word
- `mem_we`  out  1  RAM write strobe
- `mem_addr`  out  ADDR_W  RAM write address
- `mem_wdata`  out  DATA_W  RAM write data
- `cpu_rst`  out  1  core reset, active-high, to the `risc` rst input
- `cpu_pc`  in  ADDR_W  core PC register output
- `wb_valid`  in  1  one instruction retired in WB this cycle
- `rf_rd_idx`  out  IDX_W  register-file debug read index
- `rf_rd_data`  in  DATA_W  combinational read data for `rf_rd_idx`
- `dump_valid`, `dump_ready`  out/in  1  register dump handshake
- `dump_idx`  out  IDX_W  register index of the current beat
- `dump_data`  out  DATA_W  register value of the current beat
- `dump_last`  out  1  beat for register NREGS-1
- `done`  out  1  run finished and dump complete
- `timeout`  out  1  run ended by MAX_CYCLES, not by halt
- `cycles`  out  CNT_W  RUN cycles elapsed
- `retired`  out  CNT_W  instructions retired during RUN

## Operation
- The FSM has six states: IDLE, LOAD, CPURST, RUN, DUMP, DONE.
- **Reset (rst=0):**
  - The state goes to IDLE.
  - `cpu_rst`=1.
  - All other outputs are 0, and the counters and `dump_idx` are 0.
- **IDLE / DONE with start=1:**
  - The state goes to LOAD.
  - `cycles`, `retired`, `timeout`, `done` and the halt counter are cleared.
  - `cpu_rst` stays 1 through IDLE, LOAD and CPURST.
- **LOAD:**
  - `ld_ready`=1.
  - Each cycle with `ld_valid` set is a write: `mem_we`=`ld_valid`, with `mem_addr`/`mem_wdata` driven combinationally from `ld_addr`/`ld_data`.
  - A beat with `ld_last` set moves the state to CPURST.
  - There is no per-beat stall, and a zero-gap stream is legal.
- **CPURST:** lasts exactly one cycle with `cpu_rst`=1, then the state goes to RUN.
- **RUN:**
  - `cpu_rst`=0.
  - `cycles` increments every cycle and saturates at 2^CNT_W-1.
  - A registered previous PC is compared with `cpu_pc`. Equal increments the stable count; a change clears it. The first RUN cycle compares against the PC captured in CPURST.
  - Halt: stable count reaches HALT_STABLE-1 on an equal compare. The state goes to DUMP with `timeout`=0.
  - Timeout: `cycles` reaches MAX_CYCLES-1 and increments. The state goes to DUMP with `timeout`=1.
  - Simultaneous halt and timeout: halt wins and `timeout`=0.
- **DUMP:**
  - `rf_rd_idx`=`dump_idx`, `dump_data`=`rf_rd_data` and `dump_valid`=1.
  - On each beat with `dump_ready` set, `dump_idx` increments.
  - The beat with `dump_idx`=NREGS-1 asserts `dump_last`. Its handshake moves the state to DONE and returns `dump_idx` to 0.
  - The core is held at `cpu_rst`=0 but frozen by design convention: the bench stops issuing work. No writes occur because `mem_we`=0.
- **DONE:**
  - `done`=1.
  - `cycles`, `retired` and `timeout` hold until the next `start`.
- `start` outside IDLE/DONE is ignored.
- Reset asserted mid-run aborts immediately to the reset values. The core returns to reset asynchronously via `cpu_rst`=1.

## Timing
- **Load:** the write appears the same cycle as the accepted beat, with no added latency. N words take N cycles.
- **Start to first core-active cycle:** `start`@T, LOAD from T+1, last beat @L, CPURST @L+1, RUN (`cpu_rst`=0) from L+2.
- **Halt detection latency:** HALT_STABLE cycles after the PC last changed. DUMP is entered on the following edge.
- **Timeout:** DUMP is entered after exactly MAX_CYCLES RUN cycles, and `cycles`=MAX_CYCLES in DONE.
- **Dump:** NREGS handshakes. With `dump_ready` tied to 1 it takes NREGS cycles, and `done` rises on the cycle after the last beat.
- **Dump handshake:** `dump_valid` is held and the data is stable while `dump_ready`=0. `dump_data` is therefore stable only if the register file is quiescent.

## Configuration
- `RUN_CTRL_RETIRE_CNT_EN` defined: `retired` increments on each RUN cycle with `wb_valid` set and saturates like `cycles`.
- `RUN_CTRL_RETIRE_CNT_EN` undefined: the counter logic is absent, `wb_valid` is ignored, and `retired` is constant 0.

## Test plan
- **Reset:** rst=0 for 3 cycles mid-LOAD -> `cpu_rst`=1, `ld_ready`=0, `done`=0, `cycles`=0; IDLE after release.
- **Load:** 14 words (addr 0–11, 25, 26; values 993…3, 0xFFFE, 100) with back-to-back `ld_valid` -> 14 `mem_we` pulses with matching addr/data, CPURST on the cycle after the beat with `ld_last` set, `cpu_rst` falls one cycle later.
- **Halt:** with HALT_STABLE=4, PC counts 0..20 then holds at 20 -> DUMP entered 4 cycles after the PC settles, `timeout`=0, `cycles`=25.
- **Timeout:** PC changes every cycle and MAX_CYCLES=140 -> `timeout`=1, `cycles`=140 in DONE.
- **Dump back-pressure:** `dump_ready` toggles 1,0,0,1… -> 8 beats with indices 0–7 in order, data stable while stalled, `dump_last` only on index 7, then `done`=1.
- **Retire count:** with `RUN_CTRL_RETIRE_CNT_EN` defined and 37 `wb_valid` pulses -> `retired`=37; undefined -> `retired`=0; a second `start` from DONE clears all counters.
